// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator stage.
// Immediate-select codes and the buffer-occupancy state.
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/imm_format_decode.sv
// Combinational immediate extraction for I/S/B/J/U formats.
// Z (CSR uimm) format only when IMM_GEN_CSR_EN is defined.
module imm_format_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_immsrc,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] v;
  logic        unused_op;

  assign unused_op = ^in_instr[6:0];

  always_comb begin
    v       = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (in_immsrc == IMM_I):
        v = {{20{in_instr[31]}}, in_instr[31:20]};
      (in_immsrc == IMM_S):
        v = {{20{in_instr[31]}}, in_instr[31:25],
             in_instr[11:7]};
      (in_immsrc == IMM_B):
        v = {{19{in_instr[31]}}, in_instr[31],
             in_instr[7], in_instr[30:25],
             in_instr[11:8], 1'b0};
      (in_immsrc == IMM_J):
        v = {{11{in_instr[31]}}, in_instr[31],
             in_instr[19:12], in_instr[20],
             in_instr[30:21], 1'b0};
      (in_immsrc == IMM_U):
        v = {in_instr[31:12], 12'b0};
`ifdef IMM_GEN_CSR_EN
      (in_immsrc == IMM_Z):
        v = {27'b0, in_instr[19:15]};
`endif
      default:
        illegal = 1'b1;
    endcase
  end

  // v[31] is clear for Z and illegal, so this is also a zero-extend there
  assign imm = XLEN'($signed(v));

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator with a 2-entry skid buffer.
// Optional CSR uimm (Z) format: define IMM_GEN_CSR_EN.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             err_sticky,
  input  logic             err_clr
);

  state_t st, st_nx;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;
  logic [XLEN-1:0]  sk_imm;
  logic [TAG_W-1:0] sk_tag;
  logic             sk_ill;
  logic             acc, drn;
  logic             ld_dec, ld_skid, ld_sk;

  imm_format_decode #(.XLEN(XLEN)) u_dec (
    .in_instr  (in_instr),
    .in_immsrc (in_immsrc),
    .imm       (dec_imm),
    .illegal   (dec_ill)
  );

  assign in_ready  = (st != TWO);
  assign out_valid = (st != EMPTY);
  assign acc = in_valid && in_ready && !flush;
  assign drn = out_valid && out_ready;

  always_comb begin
    st_nx   = st;
    ld_dec  = 1'b0;
    ld_skid = 1'b0;
    ld_sk   = 1'b0;
    if (flush) begin
      st_nx = EMPTY;
    end else begin
      case (st)
        EMPTY: if (acc) begin
          st_nx  = ONE;
          ld_dec = 1'b1;
        end
        ONE: if (acc && drn) begin
          ld_dec = 1'b1;
        end else if (acc) begin
          st_nx = TWO;
          ld_sk = 1'b1;
        end else if (drn) begin
          st_nx = EMPTY;
        end
        TWO: if (drn) begin
          st_nx   = ONE;
          ld_skid = 1'b1;
        end
        default: st_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= EMPTY;
    else       st <= st_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_imm     <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (ld_dec) begin
      out_imm     <= dec_imm;
      out_tag     <= in_tag;
      out_illegal <= dec_ill;
    end else if (ld_skid) begin
      out_imm     <= sk_imm;
      out_tag     <= sk_tag;
      out_illegal <= sk_ill;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sk_imm <= '0;
      sk_tag <= '0;
      sk_ill <= 1'b0;
    end else if (ld_sk) begin
      sk_imm <= dec_imm;
      sk_tag <= in_tag;
      sk_ill <= dec_ill;
    end
  end

  // a new illegal accept outranks a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                err_sticky <= 1'b0;
    else if (acc && dec_ill)  err_sticky <= 1'b1;
    else if (err_clr)         err_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage at XLEN=32 and XLEN=64.
// Reference model: field arithmetic plus a 2-deep queue.
module tb_imm_gen_stage;

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        ill;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_immsrc = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic        rdy32, vld32, ill32, err32;
  logic [31:0] imm32;
  logic [7:0]  tag32;
  logic        rdy64, vld64, ill64, err64;
  logic [63:0] imm64;
  logic [7:0]  tag64;

  int n_chk = 0;
  int n_fail = 0;

  item_t mq[$];
  logic  merr = 1'b0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(8)) u32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_immsrc(in_immsrc),
    .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .out_imm(imm32),
    .out_tag(tag32), .out_illegal(ill32),
    .err_sticky(err32), .err_clr(err_clr)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(8)) u64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_immsrc(in_immsrc),
    .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .out_imm(imm64),
    .out_tag(tag64), .out_illegal(ill64),
    .err_sticky(err64), .err_clr(err_clr)
  );

  function automatic logic [63:0] ref_imm(
    input logic [31:0] i, input logic [2:0] sel,
    output logic ill);
    longint v;
    int     w;
    ill = 1'b0;
    v = 0;
    w = 0;
    case (sel)
      3'd0: begin v = i[31:20]; w = 12; end
      3'd1: begin v = i[31:25] * 32 + i[11:7]; w = 12; end
      3'd2: begin
        v = i[31] * 4096 + i[7] * 2048
          + i[30:25] * 32 + i[11:8] * 2;
        w = 13;
      end
      3'd3: begin
        v = i[31] * 1048576 + i[19:12] * 4096
          + i[20] * 2048 + i[30:21] * 2;
        w = 21;
      end
      3'd4: begin v = i[31:12] * 4096; w = 32; end
`ifdef IMM_GEN_CSR_EN
      3'd5: begin v = i[19:15]; w = 0; end
`endif
      default: ill = 1'b1;
    endcase
    if (w > 0 && v >= (longint'(1) << (w - 1)))
      v = v - (longint'(1) << w);
    return ill ? 64'd0 : 64'(v);
  endfunction

  task automatic tick();
    item_t it;
    logic  acc, drn, ill;
    acc = in_valid && mq.size() < 2 && !flush;
    drn = mq.size() > 0 && out_ready;
    it.imm = ref_imm(in_instr, in_immsrc, ill);
    it.ill = ill;
    it.tag = in_tag;
    if (flush) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(it);
    end
    if (acc && ill) merr = 1'b1;
    else if (err_clr) merr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; err_clr = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({vld32, rdy32, imm32, tag32, ill32, err32} !==
        {1'b0, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset32 v=%b r=%b imm=%h t=%h i=%b e=%b want 0 1 0 0 0 0",
               vld32, rdy32, imm32, tag32, ill32, err32);
    end
    n_chk++;
    if ({vld64, rdy64, imm64, err64} !==
        {1'b0, 1'b1, 64'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset64 v=%b r=%b imm=%h e=%b want 0 1 0 0",
               vld64, rdy64, imm64, err64);
    end
    reset = 1'b0;
    mq.delete();
    merr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vi[6]  = '{32'hFFF00093, 32'h00112623,
                            32'hFE000EE3, 32'h123450B7,
                            32'h800000B7, 32'h7FFFF0EF};
    logic [2:0]  vs[6]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd4, 3'd3};
    logic [63:0] ve[6]  = '{64'hFFFFFFFFFFFFFFFF,
                            64'h000000000000000C,
                            64'hFFFFFFFFFFFFFFFC,
                            64'h0000000012345000,
                            64'hFFFFFFFF80000000,
                            64'h00000000000FFFFE};
    idle();
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_instr = vi[k];
      in_immsrc = vs[k]; in_tag = 8'(8'h10 + k);
      tick();
      n_chk++;
      if (!vld32 || imm32 !== ve[k][31:0] ||
          tag32 !== 8'(8'h10 + k) || ill32 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b32[%0d] v=%b imm=%h tag=%h ill=%b want imm=%h tag=%h",
                 k, vld32, imm32, tag32, ill32, ve[k][31:0], 8'(8'h10 + k));
      end
      n_chk++;
      if (!vld64 || imm64 !== ve[k] || tag64 !== 8'(8'h10 + k)) begin
        n_fail++;
        $display("FAIL b2b64[%0d] imm=%h tag=%h want %h",
                 k, imm64, tag64, ve[k]);
      end
    end
    idle();
    out_ready = 1;
    tick();
    n_chk++;
    if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain v32=%b v64=%b want 0", vld32, vld64);
    end
  endtask

  task automatic test_backpressure();
    int nxt = 1;
    int exp_t = 1;
    idle();
    in_instr = 32'h00100093; in_immsrc = 3'd0;
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 3);
      in_valid  = (nxt <= 4);
      in_tag    = 8'(nxt);
      if (c == 3) begin
        n_chk++;
        if (rdy32 !== 1'b0 || tag32 !== 8'd1 || !vld32) begin
          n_fail++;
          $display("FAIL bp_stall rdy=%b tag=%0d v=%b want 0 1 1",
                   rdy32, tag32, vld32);
        end
      end
      if (vld32 && out_ready) begin
        n_chk++;
        if (tag32 !== 8'(exp_t)) begin
          n_fail++;
          $display("FAIL bp_order tag=%0d want %0d", tag32, exp_t);
        end
        exp_t++;
      end
      if (in_valid && rdy32) nxt++;
      tick();
    end
    n_chk++;
    if (exp_t !== 5 || vld32 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_count drained=%0d v=%b want 4 0",
               exp_t - 1, vld32);
    end
    idle();
  endtask

  task automatic test_illegal();
    idle();
    out_ready = 1; in_valid = 1;
    in_instr = 32'hFFFFFFFF; in_immsrc = 3'd7; in_tag = 8'h77;
    tick();
    n_chk++;
    if (imm32 !== 32'd0 || ill32 !== 1'b1 || err32 !== 1'b1 ||
        imm64 !== 64'd0 || err64 !== 1'b1) begin
      n_fail++;
      $display("FAIL ill7 imm=%h ill=%b err=%b want 0 1 1",
               imm32, ill32, err32);
    end
    in_valid = 0;
    tick();
    n_chk++;
    if (err32 !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_hold err=%b want 1", err32);
    end
    in_valid = 1; err_clr = 1; in_immsrc = 3'd6;
    tick();
    n_chk++;
    if (err32 !== 1'b1 || ill32 !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_setwins err=%b ill=%b want 1 1", err32, ill32);
    end
    in_valid = 0;
    tick();
    n_chk++;
    if (err32 !== 1'b0 || err64 !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_clr err=%b want 0", err32);
    end
    err_clr = 0; in_valid = 1;
    in_instr = 32'h0002D073; in_immsrc = 3'd5;
    tick();
    n_chk++;
`ifdef IMM_GEN_CSR_EN
    if (imm32 !== 32'd5 || ill32 !== 1'b0 || err32 !== 1'b0) begin
      n_fail++;
      $display("FAIL z_fmt imm=%h ill=%b err=%b want 5 0 0",
               imm32, ill32, err32);
    end
`else
    if (imm32 !== 32'd0 || ill32 !== 1'b1 || err32 !== 1'b1) begin
      n_fail++;
      $display("FAIL z_ill imm=%h ill=%b err=%b want 0 1 1",
               imm32, ill32, err32);
    end
`endif
    idle();
    err_clr = 1;
    tick();
    err_clr = 0;
  endtask

  task automatic test_flush();
    idle();
    in_valid = 1; in_immsrc = 3'd0;
    in_instr = 32'h00500093;
    in_tag = 8'hA1; tick();
    in_tag = 8'hA2; tick();
    n_chk++;
    if (rdy32 !== 1'b0 || vld32 !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_two rdy=%b v=%b want 0 1", rdy32, vld32);
    end
    flush = 1; in_tag = 8'hEE; in_immsrc = 3'd7;
    tick();
    n_chk++;
    if (vld32 !== 1'b0 || rdy32 !== 1'b1 || err32 !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_clear v=%b rdy=%b err=%b want 0 1 0",
               vld32, rdy32, err32);
    end
    idle();
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
        n_fail++;
        $display("FAIL fl_ghost cyc=%0d v=%b tag=%h want 0",
                 k, vld32, tag32);
      end
    end
  endtask

  task automatic test_reset_two();
    idle();
    in_valid = 1; in_immsrc = 3'd1;
    in_instr = 32'hFE112E23;
    in_tag = 8'h31; tick();
    in_immsrc = 3'd7; in_tag = 8'h32; tick();
    in_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({vld32, rdy32, imm32, tag32, ill32, err32} !==
        {1'b0, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_two v=%b r=%b imm=%h t=%h i=%b e=%b want 0 1 0 0 0 0",
               vld32, rdy32, imm32, tag32, ill32, err32);
    end
    mq.delete();
    merr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      in_instr  = $urandom;
      in_immsrc = 3'($urandom_range(0, 7));
      in_tag    = 8'($urandom);
      err_clr   = ($urandom_range(0, 15) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
      n_chk++;
      if (vld32 !== (mq.size() > 0) || rdy32 !== (mq.size() < 2) ||
          err32 !== merr || vld64 !== vld32 || err64 !== merr) begin
        n_fail++;
        $display("FAIL rnd_ctl cyc=%0d v=%b r=%b e=%b want v=%b r=%b e=%b",
                 c, vld32, rdy32, err32, mq.size() > 0,
                 mq.size() < 2, merr);
      end
      if (mq.size() > 0) begin
        n_chk++;
        if (imm32 !== mq[0].imm[31:0] || imm64 !== mq[0].imm ||
            tag32 !== mq[0].tag || ill32 !== mq[0].ill ||
            tag64 !== mq[0].tag || ill64 !== mq[0].ill) begin
          n_fail++;
          $display("FAIL rnd_data cyc=%0d imm=%h/%h t=%h i=%b want %h t=%h i=%b",
                   c, imm32, imm64, tag32, ill32,
                   mq[0].imm, mq[0].tag, mq[0].ill);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_two();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
